// File: rtl/img_win_ctl.sv
// Sliding-window frame controller: reads KROWS stacked words per column, runs the
// window pipeline PIX_PER_WORD cycles per word and writes one result word per column.
module img_win_ctl #(
    parameter int COL_MAX      = 600,
    parameter int ROW_MAX      = 400,
    parameter int PIX_PER_WORD = 4,
    parameter int KROWS        = 3,
    parameter int AW           = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic                       cont_i,
    input  logic [AW-1:0]              src_base_i,
    input  logic [AW-1:0]              dst_base_i,
    output logic                       bus_cs_n,
    output logic                       bus_we_o,
    output logic [AW-1:0]              bus_addr_o,
    input  logic                       bus_ack_i,
    output logic [KROWS-1:0]           load_o,
    output logic                       en_pipe,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [$clog2(ROW_MAX)-1:0] row_o
);

    localparam int WORDS = COL_MAX / PIX_PER_WORD;
    localparam int OROWS = ROW_MAX - KROWS + 1;
    localparam int RW    = $clog2(ROW_MAX);
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int KW    = $clog2(KROWS);
    localparam int PW    = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

    localparam logic [RW-1:0] R_LAST  = RW'(OROWS - 1);
    localparam logic [CW-1:0] C_LAST  = CW'(WORDS - 1);
    localparam logic [KW-1:0] K_LAST  = KW'(KROWS - 1);
    localparam logic [PW-1:0] P_LAST  = PW'(PIX_PER_WORD - 1);
    localparam logic [AW-1:0] WORDS_A = AW'(WORDS);

    typedef enum logic [2:0] {IDLE, RD, RUN, WR, FLUSH} state_t;

    state_t          state, state_d;
    logic [RW-1:0]   row, row_d;
    logic [CW-1:0]   col, col_d;
    logic [KW-1:0]   k, k_d;
    logic [PW-1:0]   cyc, cyc_d;
    logic            flush, flush_d;
    logic            pend, pend_d;
    logic [AW-1:0]   src, src_d, dst, dst_d;
    logic            cs_n_d, we_d, done_d, aborted_d;
    logic [AW-1:0]   addr_d, rd_addr, wr_addr;

    assign rd_addr = src + (AW'(row) + AW'(k)) * WORDS_A + AW'(col);
    assign wr_addr = dst + AW'(row) * WORDS_A
                   + (flush ? AW'(WORDS - 1) : (AW'(col) - AW'(1)));
    assign busy    = (state != IDLE);
    assign row_o   = row;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            k          <= '0;
            cyc        <= '0;
            flush      <= 1'b0;
            pend       <= 1'b0;
            src        <= '0;
            dst        <= '0;
            bus_cs_n   <= 1'b1;
            bus_we_o   <= 1'b0;
            bus_addr_o <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            state      <= state_d;
            row        <= row_d;
            col        <= col_d;
            k          <= k_d;
            cyc        <= cyc_d;
            flush      <= flush_d;
            pend       <= pend_d;
            src        <= src_d;
            dst        <= dst_d;
            bus_cs_n   <= cs_n_d;
            bus_we_o   <= we_d;
            bus_addr_o <= addr_d;
            done       <= done_d;
            aborted    <= aborted_d;
        end
    end

    // Bus states alternate an issue cycle (cs_n high) with a held request, which
    // yields the mandatory one-cycle gap between back-to-back transactions.
    always_comb begin
        state_d   = state;
        row_d     = row;
        col_d     = col;
        k_d       = k;
        cyc_d     = cyc;
        flush_d   = flush;
        pend_d    = pend;
        src_d     = src;
        dst_d     = dst;
        cs_n_d    = bus_cs_n;
        we_d      = bus_we_o;
        addr_d    = bus_addr_o;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        load_o    = '0;
        en_pipe   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i && !abort_i) begin
                    src_d   = src_base_i;
                    dst_d   = dst_base_i;
                    row_d   = '0;
                    col_d   = '0;
                    k_d     = '0;
                    cyc_d   = '0;
                    flush_d = 1'b0;
                    pend_d  = 1'b0;
                    state_d = RD;
                end
            end
            RD, WR: begin
                if (bus_cs_n) begin
                    if (pend || abort_i) begin
                        pend_d    = 1'b0;
                        aborted_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cs_n_d = 1'b0;
                        we_d   = (state == WR);
                        addr_d = (state == WR) ? wr_addr : rd_addr;
                    end
                end else if (!bus_ack_i) begin
                    if (abort_i) pend_d = 1'b1;
                end else begin
                    cs_n_d = 1'b1;
                    we_d   = 1'b0;
                    pend_d = 1'b0;
                    if (state == RD) load_o = KROWS'(1) << k;
                    if (pend || abort_i) begin
                        aborted_d = 1'b1;
                        state_d   = IDLE;
                    end else if (state == RD) begin
                        if (k != K_LAST) begin
                            k_d = k + KW'(1);
                        end else begin
                            k_d     = '0;
                            cyc_d   = '0;
                            state_d = RUN;
                        end
                    end else if (!flush) begin
                        if (col == C_LAST) begin
                            flush_d = 1'b1;
                            cyc_d   = '0;
                            state_d = FLUSH;
                        end else begin
                            col_d   = col + CW'(1);
                            state_d = RD;
                        end
                    end else if (row != R_LAST) begin
                        row_d   = row + RW'(1);
                        col_d   = '0;
                        flush_d = 1'b0;
                        state_d = RD;
                    end else begin
                        done_d = 1'b1;
                        if (cont_i) begin
                            row_d   = '0;
                            col_d   = '0;
                            flush_d = 1'b0;
                            src_d   = src_base_i;
                            dst_d   = dst_base_i;
                            state_d = RD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            RUN, FLUSH: begin
                en_pipe = 1'b1;
                if (abort_i) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (cyc != P_LAST) begin
                    cyc_d = cyc + PW'(1);
                end else begin
                    cyc_d = '0;
                    // The first column only primes the pipeline; nothing is written for it.
                    if (state == FLUSH || col != '0) begin
                        state_d = WR;
                    end else if (WORDS == 1) begin
                        flush_d = 1'b1;
                        state_d = FLUSH;
                    end else begin
                        col_d   = CW'(1);
                        state_d = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_img_win_ctl.sv
// Directed bench for img_win_ctl: a bus slave with programmable ack delay, a
// transaction/run logger, and hand-computed expected event sequences.
module tb_img_win_ctl;

    localparam logic [31:0] R4 = 32'h8000_0004;
    localparam logic [31:0] W  = 32'h4000_0000;
    localparam logic [31:0] D0 = 32'hD000_0000;
    localparam logic [31:0] D1 = 32'hD000_0001;
    localparam logic [31:0] A0 = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0, abort_i = 1'b0, cont_i = 1'b0;
    logic [19:0] src_base_i = '0, dst_base_i = '0;
    logic        bus_cs_n, bus_we_o, bus_ack_i = 1'b0;
    logic [19:0] bus_addr_o;
    logic [2:0]  load_o;
    logic        en_pipe, busy, done, aborted;
    logic [1:0]  row_o;

    logic        start1 = 1'b0, abort1 = 1'b0, cont1 = 1'b0;
    logic        cs_n1, we1, ack1 = 1'b0;
    logic [19:0] addr1;
    logic [2:0]  load1;
    logic        en1, busy1, done1, ab1;
    logic [1:0]  row1;

    int          vectors = 0, miscompares = 0;
    int          ack_delay = 0;
    logic [31:0] log_q[$], log1_q[$], exp_q[$], frame_q[$];
    int          viol = 0, viol1 = 0, cs_low_cnt = 0, done_cnt = 0;

    img_win_ctl #(.COL_MAX(8), .ROW_MAX(4), .PIX_PER_WORD(4), .KROWS(3), .AW(20)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .cont_i(cont_i),
        .src_base_i(src_base_i), .dst_base_i(dst_base_i),
        .bus_cs_n(bus_cs_n), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_ack_i(bus_ack_i),
        .load_o(load_o), .en_pipe(en_pipe), .busy(busy), .done(done), .aborted(aborted),
        .row_o(row_o));

    img_win_ctl #(.COL_MAX(4), .ROW_MAX(3), .PIX_PER_WORD(4), .KROWS(3), .AW(20)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .abort_i(abort1), .cont_i(cont1),
        .src_base_i(src_base_i), .dst_base_i(dst_base_i),
        .bus_cs_n(cs_n1), .bus_we_o(we1), .bus_addr_o(addr1), .bus_ack_i(ack1),
        .load_o(load1), .en_pipe(en1), .busy(busy1), .done(done1), .aborted(ab1),
        .row_o(row1));

    always #5 clk = ~clk;

    // Slave answers on the falling edge; the logger looks 1 ns later so that the
    // combinational load strobe has settled on the new ack value.
    int          wait_cnt = 0, run_len = 0, rdn = 0;
    logic        in_txn = 1'b0, prev_pend = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
    logic [19:0] prev_addr = '0;
    logic [2:0]  exp_load;
    always @(negedge clk) begin
        if (!bus_cs_n) begin
            if (!in_txn) begin
                in_txn   = 1'b1;
                wait_cnt = (ack_delay < 0) ? int'($urandom_range(3, 0)) : ack_delay;
            end
            if (wait_cnt == 0) bus_ack_i = 1'b1;
            else begin
                wait_cnt--;
                bus_ack_i = 1'b0;
            end
        end else begin
            bus_ack_i = 1'b0;
            in_txn    = 1'b0;
        end
        #1;
        if (rst) begin
            prev_pend = 1'b0;
            prev_ack  = 1'b0;
            run_len   = 0;
            rdn       = 0;
        end else begin
            if (!busy) rdn = 0;
            if (en_pipe) run_len++;
            else if (run_len > 0) begin
                log_q.push_back(32'h8000_0000 | 32'(run_len));
                run_len = 0;
            end
            if (!bus_cs_n) cs_low_cnt++;
            if (en_pipe && !bus_cs_n) viol++;
            if (!bus_cs_n && prev_ack) viol++;
            if (prev_pend && (bus_cs_n || bus_addr_o !== prev_addr || bus_we_o !== prev_we)) viol++;
            exp_load = '0;
            if (!bus_cs_n && bus_ack_i) begin
                log_q.push_back(bus_we_o ? (W | 32'(bus_addr_o)) : 32'(bus_addr_o));
                if (!bus_we_o) begin
                    exp_load = 3'b001 << (rdn % 3);
                    rdn++;
                end
            end
            if (load_o !== exp_load) viol++;
            if (done) begin
                log_q.push_back(D0 | 32'(busy));
                done_cnt++;
            end
            if (aborted) log_q.push_back(A0 | 32'(busy));
            prev_pend = !bus_cs_n && !bus_ack_i;
            prev_ack  = !bus_cs_n && bus_ack_i;
            prev_addr = bus_addr_o;
            prev_we   = bus_we_o;
        end
    end

    int run1 = 0;
    always @(negedge clk) begin
        ack1 = !cs_n1;
        #1;
        if (!rst) begin
            if (en1) run1++;
            else if (run1 > 0) begin
                log1_q.push_back(32'h8000_0000 | 32'(run1));
                run1 = 0;
            end
            if (en1 && !cs_n1) viol1++;
            if (!cs_n1 && ack1) log1_q.push_back(we1 ? (W | 32'(addr1)) : 32'(addr1));
            if (done1) log1_q.push_back(D0 | 32'(busy1));
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        assert (got === expv)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic c,
                                 input logic [19:0] src, input logic [19:0] dst);
        start_i    = s;
        abort_i    = a;
        cont_i     = c;
        src_base_i = src;
        dst_base_i = dst;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
    endtask

    task automatic compareLog(input string tag, input bit which, input int base);
        int          n;
        logic [31:0] got;
        n = which ? log1_q.size() : log_q.size();
        checkOutput({tag, " len"}, 32'(n - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < n) got = which ? log1_q[base + i] : log_q[base + i];
            else got = 32'hFFFF_FFFF;
            checkOutput($sformatf("%s[%0d]", tag, i), got, exp_q[i]);
        end
    endtask

    task automatic waitIdle(input string tag, input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            tick();
            n++;
        end
        checkOutput({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " cs_n"}, 32'(bus_cs_n), 32'd1);
        checkOutput({tag, " we"}, 32'(bus_we_o), 32'd0);
        checkOutput({tag, " addr"}, 32'(bus_addr_o), 32'd0);
        checkOutput({tag, " load"}, 32'(load_o), 32'd0);
        checkOutput({tag, " en"}, 32'(en_pipe), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " aborted"}, 32'(aborted), 32'd0);
        checkOutput({tag, " row"}, 32'(row_o), 32'd0);
    endtask

    initial begin
        int base, n, c0;
        frame_q = '{32'h100, 32'h102, 32'h104, R4, 32'h101, 32'h103, 32'h105, R4,
                    W | 32'h200, R4, W | 32'h201,
                    32'h102, 32'h104, 32'h106, R4, 32'h103, 32'h105, 32'h107, R4,
                    W | 32'h202, R4, W | 32'h203};

        tick();
        tick();
        checkReset("reset");
        checkOutput("reset cs_n1", 32'(cs_n1), 32'd1);
        checkOutput("reset busy1", 32'(busy1), 32'd0);
        rst = 1'b0;
        tick();

        $display("[TB] basic frame, immediate ack, late start ignored");
        ack_delay = 0;
        base = log_q.size();
        applyStimulus(1'b1, 1'b0, 1'b0, 20'h100, 20'h200);
        repeat (5) tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 20'h300, 20'h340);
        waitIdle("basic", 1000);
        exp_q = frame_q;
        exp_q.push_back(D0);
        compareLog("basic", 1'b0, base);
        checkOutput("basic viol", 32'(viol), 32'd0);

        $display("[TB] basic frame, random ack delay");
        ack_delay = -1;
        base = log_q.size();
        applyStimulus(1'b1, 1'b0, 1'b0, 20'h100, 20'h200);
        waitIdle("rand", 2000);
        compareLog("rand", 1'b0, base);
        checkOutput("rand viol", 32'(viol), 32'd0);

        $display("[TB] single-word frame");
        base = log1_q.size();
        src_base_i = 20'h100;
        dst_base_i = 20'h200;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (busy1 && n < 500) begin
            tick();
            n++;
        end
        checkOutput("w1 idle", 32'(busy1), 32'd0);
        exp_q = '{32'h100, 32'h101, 32'h102, 32'h8000_0008, W | 32'h200, D0};
        compareLog("w1", 1'b1, base);
        checkOutput("w1 viol", 32'(viol1), 32'd0);

        $display("[TB] continuous mode, two frames");
        ack_delay = 0;
        base = log_q.size();
        c0 = done_cnt;
        applyStimulus(1'b1, 1'b0, 1'b1, 20'h100, 20'h200);
        n = 0;
        while (done_cnt == c0 && n < 1000) begin
            tick();
            n++;
        end
        checkOutput("cont first done", 32'(done_cnt - c0), 32'd1);
        cont_i = 1'b0;
        waitIdle("cont", 1000);
        exp_q = frame_q;
        exp_q.push_back(D1);
        foreach (frame_q[i]) exp_q.push_back(frame_q[i]);
        exp_q.push_back(D0);
        compareLog("cont", 1'b0, base);

        $display("[TB] abort during a held-off read");
        ack_delay = 2;
        base = log_q.size();
        applyStimulus(1'b1, 1'b0, 1'b0, 20'h100, 20'h200);
        n = 0;
        while (bus_cs_n && n < 50) begin
            tick();
            n++;
        end
        checkOutput("abort rd seen", 32'(bus_cs_n), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 20'h100, 20'h200);
        repeat (10) tick();
        c0 = cs_low_cnt;
        repeat (20) tick();
        checkOutput("abort quiet", 32'(cs_low_cnt - c0), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        exp_q = '{32'h100, A0};
        compareLog("abort rd", 1'b0, base);

        $display("[TB] abort during run");
        ack_delay = 0;
        base = log_q.size();
        applyStimulus(1'b1, 1'b0, 1'b0, 20'h100, 20'h200);
        n = 0;
        while (!en_pipe && n < 50) begin
            tick();
            n++;
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 20'h100, 20'h200);
        repeat (5) tick();
        exp_q = '{32'h100, 32'h102, 32'h104, 32'h8000_0001, A0};
        compareLog("abort run", 1'b0, base);

        $display("[TB] start with abort in idle");
        base = log_q.size();
        applyStimulus(1'b1, 1'b1, 1'b0, 20'h100, 20'h200);
        repeat (5) tick();
        checkOutput("start+abort busy", 32'(busy), 32'd0);
        checkOutput("start+abort events", 32'(log_q.size() - base), 32'd0);

        $display("[TB] reset during a write");
        ack_delay = 2;
        applyStimulus(1'b1, 1'b0, 1'b0, 20'h100, 20'h200);
        n = 0;
        while (!(!bus_cs_n && bus_we_o) && n < 500) begin
            tick();
            n++;
        end
        checkOutput("midwr seen", 32'(bus_we_o), 32'd1);
        rst = 1'b1;
        tick();
        checkReset("midwr reset");
        rst = 1'b0;
        tick();
        ack_delay = 0;
        base = log_q.size();
        applyStimulus(1'b1, 1'b0, 1'b0, 20'h100, 20'h200);
        waitIdle("after reset", 1000);
        exp_q = frame_q;
        exp_q.push_back(D0);
        compareLog("after reset", 1'b0, base);
        checkOutput("final viol", 32'(viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
